regfile_op_sequencer: RTL and testbench

- Initiator-side controller for the 64x32 register file (ra1/ra2/wa/wd/we/rd1/rd2 interface).
- Accepts one register-to-register or register-to-immediate instruction through a valid/ready handshake and reads source operands from the register file.
- Executes the instruction through an internal 32-bit ALU stage and writes the result back to the register file.
- Sits between the instruction decode stage and regfile_32bit. It is the only writer of the register file in the datapath.

---
 rtl/regfile_op_sequencer.sv | 174 +++++++++++++++++
 tb/tb_regfile_op_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_op_sequencer.sv
// Initiator-side controller for the 64x32 register file: accepts one instruction,
// fetches its operands, runs it through a 32-bit ALU and writes the result back.
module regfile_op_sequencer #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [RWIDTH-1:0] instr_rd,
  input  logic [RWIDTH-1:0] instr_rs1,
  input  logic [RWIDTH-1:0] instr_rs2,
  input  logic              instr_use_imm,
  input  logic [DWIDTH-1:0] instr_imm,
  output logic [RWIDTH-1:0] rf_ra1,
  output logic [RWIDTH-1:0] rf_ra2,
  input  logic [DWIDTH-1:0] rf_rd1,
  input  logic [DWIDTH-1:0] rf_rd2,
  output logic [RWIDTH-1:0] rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  output logic              rf_we,
  output logic              res_valid,
  output logic [DWIDTH-1:0] res_data,
  output logic              res_zero,
  output logic              res_carry,
  output logic              res_ovf,
  output logic              res_err
);

  localparam int SHW = $clog2(DWIDTH);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_PASSB = 4'd11
  } op_t;

  state_t state, state_n;

  logic [3:0]        op_q;
  logic [RWIDTH-1:0] rd_q;
  logic              use_imm_q;
  logic [DWIDTH-1:0] imm_q;
  logic [DWIDTH-1:0] opa, opb;

  logic              accept;
  logic              is_sub;
  logic [DWIDTH-1:0] b_eff;
  logic [DWIDTH:0]   sum;
  logic [SHW-1:0]    shamt;
  logic [DWIDTH-1:0] alu_res;
  logic              alu_carry, alu_ovf, alu_err;

  assign instr_ready = (state == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = FETCH;
      FETCH:   state_n = EXEC;
      EXEC:    state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One shared adder: SUB is A + ~B + 1, so carry-out set means no borrow.
  always_comb begin
    is_sub    = (op_q == OP_SUB);
    b_eff     = is_sub ? ~opb : opb;
    sum       = {1'b0, opa} + {1'b0, b_eff} + {{DWIDTH{1'b0}}, is_sub};
    shamt     = opb[SHW-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res   = sum[DWIDTH-1:0];
        alu_carry = sum[DWIDTH];
        alu_ovf   = (opa[DWIDTH-1] == b_eff[DWIDTH-1]) && (sum[DWIDTH-1] != opa[DWIDTH-1]);
      end
      OP_AND:   alu_res = opa & opb;
      OP_OR:    alu_res = opa | opb;
      OP_XOR:   alu_res = opa ^ opb;
      OP_NOR:   alu_res = ~(opa | opb);
      OP_SLT:   alu_res = {{(DWIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLTU:  alu_res = {{(DWIDTH-1){1'b0}}, (opa < opb)};
      OP_SLL:   alu_res = opa << shamt;
      OP_SRL:   alu_res = opa >> shamt;
      OP_SRA:   alu_res = DWIDTH'($signed(opa) >>> shamt);
      OP_PASSB: alu_res = opb;
      default:  alu_err = 1'b1;
    endcase
  end

  // Results are registered on the EXEC->WRITE edge so they are stable for the
  // whole WRITE cycle; the read addresses double as the captured rs1/rs2.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      opa       <= '0;
      opb       <= '0;
      rf_ra1    <= '0;
      rf_ra2    <= '0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      rf_we     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      rf_we     <= 1'b0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= instr_op;
            rd_q      <= instr_rd;
            use_imm_q <= instr_use_imm;
            imm_q     <= instr_imm;
            rf_ra1    <= instr_rs1;
            rf_ra2    <= instr_rs2;
          end
        end
        FETCH: begin
          opa <= rf_rd1;
          opb <= use_imm_q ? imm_q : rf_rd2;
        end
        EXEC: begin
          res_valid <= 1'b1;
          res_err   <= alu_err;
          res_data  <= alu_res;
          res_zero  <= !alu_err && (alu_res == '0);
          res_carry <= alu_carry;
          res_ovf   <= alu_ovf;
          if (!alu_err) begin
            rf_we <= 1'b1;
            rf_wa <= rd_q;
            rf_wd <= alu_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural 64x32 register file.
module tb_regfile_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [5:0]  instr_rd, instr_rs1, instr_rs2;
  logic        instr_use_imm;
  logic [31:0] instr_imm;
  logic [5:0]  rf_ra1, rf_ra2, rf_wa;
  logic [31:0] rf_rd1, rf_rd2, rf_wd;
  logic        rf_we;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_zero, res_carry, res_ovf, res_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [64];
  logic        preload;

  regfile_op_sequencer #(.RWIDTH(6), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
    .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero),
    .res_carry(res_carry), .res_ovf(res_ovf), .res_err(res_err)
  );

  always #5 clk = ~clk;

  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) regs[i] <= 32'h1000_0000 + 32'(i);
    end else if (rf_we) begin
      regs[rf_wa] <= rf_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, input logic c, input logic o);
    check({tag, "/zero"},  32'(res_zero),  32'(z));
    check({tag, "/carry"}, 32'(res_carry), 32'(c));
    check({tag, "/ovf"},   32'(res_ovf),   32'(o));
  endtask

  // Entered and left at 1 time unit after a rising edge with the sequencer idle.
  task automatic run(input string tag, input logic [3:0] op, input logic [5:0] rd,
                     input logic [5:0] rs1, input logic [5:0] rs2, input logic ui,
                     input logic [31:0] imm, input logic [31:0] exp_data, input logic exp_we);
    int cyc;
    int early_we;
    check({tag, "/ready"}, 32'(instr_ready), 32'd1);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_use_imm = ui; instr_imm = imm; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    // scramble the fields while busy; the captured copy must be used
    instr_op = 4'd2; instr_rd = 6'd62; instr_rs1 = 6'd61; instr_rs2 = 6'd60;
    instr_use_imm = ~ui; instr_imm = 32'h5555_5555;
    cyc = 0; early_we = 0;
    while (!res_valid && cyc < 8) begin
      if (rf_we) early_we++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), 32'd2);
    check({tag, "/early_we"}, 32'(early_we), 32'd0);
    check({tag, "/we"}, 32'(rf_we), 32'(exp_we));
    if (exp_we) check({tag, "/wa"}, 32'(rf_wa), 32'(rd));
    if (exp_we) check({tag, "/wd"}, rf_wd, exp_data);
    check({tag, "/data"}, res_data, exp_data);
    check({tag, "/err"}, 32'(res_err), 32'(!exp_we));
    @(posedge clk); #1;
    check({tag, "/we_pulse"}, 32'(rf_we), 32'd0);
    check({tag, "/valid_pulse"}, 32'(res_valid), 32'd0);
    check({tag, "/ready_after"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    int n;
    int cnt;
    preload = 1'b1;
    rst = 1'b1;
    instr_valid = 1'b1; instr_op = 4'd11; instr_rd = 6'd5; instr_rs1 = 6'd1;
    instr_rs2 = 6'd2; instr_use_imm = 1'b1; instr_imm = 32'h1234_5678;

    repeat (2) begin
      @(posedge clk); #1;
      check("rst/ready", 32'(instr_ready), 32'd0);
      check("rst/we", 32'(rf_we), 32'd0);
      check("rst/valid", 32'(res_valid), 32'd0);
    end
    check("rst/res_data", res_data, 32'd0);
    rst = 1'b0; instr_valid = 1'b0; preload = 1'b0;
    #1;
    check("rst/ready_release", 32'(instr_ready), 32'd1);
    check("rst/ra1", 32'(rf_ra1), 32'd0);
    check("rst/wa", 32'(rf_wa), 32'd0);

    run("passb63", 4'd11, 6'd63, 6'd0, 6'd0, 1'b1, 32'hFFAA_FFAA, 32'hFFAA_FFAA, 1'b1);
    check("passb63/zero", 32'(res_zero), 32'd0);
    check("passb63/reg", regs[63], 32'hFFAA_FFAA);

    // Back-to-back: valid held high, ready must come back 4 edges after accept.
    instr_op = 4'd11; instr_rd = 6'd10; instr_use_imm = 1'b1; instr_imm = 32'h0000_5A5A;
    instr_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!instr_ready && n < 10);
    instr_valid = 1'b0;
    check("thru/gap", 32'(n), 32'd4);
    check("thru/reg", regs[10], 32'h0000_5A5A);

    run("pre_r1", 4'd11, 6'd1, 6'd0, 6'd0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    run("pre_r2", 4'd11, 6'd2, 6'd0, 6'd0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1);
    run("pre_r5", 4'd11, 6'd5, 6'd0, 6'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    run("add", 4'd0, 6'd3, 6'd1, 6'd2, 1'b0, 32'd0, 32'h8000_0000, 1'b1);
    check_flags("add", 1'b0, 1'b0, 1'b1);
    run("sub", 4'd1, 6'd4, 6'd2, 6'd2, 1'b0, 32'd0, 32'h0000_0000, 1'b1);
    check_flags("sub", 1'b1, 1'b1, 1'b0);

    run("slt", 4'd6, 6'd6, 6'd5, 6'd2, 1'b0, 32'd0, 32'd1, 1'b1);
    check_flags("slt", 1'b0, 1'b0, 1'b0);
    run("sltu", 4'd7, 6'd6, 6'd5, 6'd2, 1'b0, 32'd0, 32'd0, 1'b1);
    check("sltu/zero", 32'(res_zero), 32'd1);
    run("sra", 4'd10, 6'd8, 6'd3, 6'd0, 1'b1, 32'd4, 32'hF800_0000, 1'b1);
    run("srl", 4'd9, 6'd8, 6'd3, 6'd0, 1'b1, 32'd4, 32'h0800_0000, 1'b1);
    run("sll", 4'd8, 6'd9, 6'd2, 6'd0, 1'b1, 32'd31, 32'h8000_0000, 1'b1);
    check("sll/reg", regs[9], 32'h8000_0000);

    run("illegal", 4'd13, 6'd12, 6'd1, 6'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    check("illegal/reg", regs[12], 32'h1000_000C);
    // rs1 == rd: old r1 is read, sum is written back into r1
    run("same_rd", 4'd0, 6'd1, 6'd1, 6'd0, 1'b1, 32'd1, 32'h8000_0000, 1'b1);
    check_flags("same_rd", 1'b0, 1'b0, 1'b1);
    check("same_rd/reg", regs[1], 32'h8000_0000);

    // Reset during EXEC must abort the in-flight write.
    instr_op = 4'd0; instr_rd = 6'd7; instr_rs1 = 6'd1; instr_rs2 = 6'd2;
    instr_use_imm = 1'b0; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort/we", 32'(rf_we), 32'd0);
    check("abort/valid", 32'(res_valid), 32'd0);
    check("abort/ready_in_rst", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort/ready", 32'(instr_ready), 32'd1);
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rf_we || res_valid) cnt++;
    end
    check("abort/no_activity", 32'(cnt), 32'd0);
    check("abort/reg", regs[7], 32'h1000_0007);
    run("readback", 4'd0, 6'd11, 6'd7, 6'd0, 1'b1, 32'd0, 32'h1000_0007, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
